// File: rtl/key_play_arbiter_if.sv
// Request/playback bus between the key channels, the shared audio player and the arbiter.
interface key_play_arbiter_if;
  logic [3:0] req_in;
  logic       play_done;
  logic       play_start;
  logic [1:0] play_sel;
  logic       busy;
  logic [3:0] pending;
  logic       timeout_err;

  modport master (
    output req_in, play_done,
    input  play_start, play_sel, busy, pending, timeout_err
  );

  modport slave (
    input  req_in, play_done,
    output play_start, play_sel, busy, pending, timeout_err
  );
endinterface

// File: rtl/key_play_arbiter.sv
// Round-robin arbiter granting four edge-captured key requests to one shared audio player,
// with a bounded wait for the player's completion pulse.
module key_play_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input logic              clk,
  input logic              reset,
  key_play_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [3:0]  prev_r;
  logic [3:0]  pending_r;
  logic [3:0]  pending_s;
  logic [3:0]  rise_s;
  logic [3:0]  clr_s;
  logic [1:0]  sel_r;
  logic [1:0]  last_r;
  logic [1:0]  win_s;
  logic        win_vld_s;
  logic [15:0] cnt_r;
  logic        cnt_hit_s;
  logic        timeout_s;
  logic        play_start_r;
  logic        busy_r;
  logic        timeout_err_r;

  // Lowest offset from last grant wins: iterate far-to-near so the nearest hit overwrites.
  function automatic logic [2:0] rr_pick(input logic [3:0] pend, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] c;
    res = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      c   = last + 2'(i);
      res = pend[c] ? {1'b1, c} : res;
    end
    return res;
  endfunction

  assign rise_s               = bus.req_in & ~prev_r;
  assign {win_vld_s, win_s}   = rr_pick(pending_r, last_r);
  assign cnt_hit_s            = (cnt_r == 16'(TIMEOUT - 1));

  // Pending update: a fresh rise on the clearing edge re-sets the bit.
  always_comb begin
    clr_s = 4'b0000;
    if (state_r == START) begin
      clr_s = 4'b0001 << sel_r;
    end else begin
      clr_s = 4'b0000;
    end
    pending_s = (pending_r & ~clr_s) | rise_s;
  end

  // Next-state logic; play_done is only honoured in WAIT and beats a coincident timeout.
  always_comb begin
    state_s   = state_r;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (win_vld_s) begin
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        state_s = WAIT;
      end
      WAIT: begin
        if (bus.play_done) begin
          state_s = IDLE;
        end else if (cnt_hit_s) begin
          state_s   = IDLE;
          timeout_s = 1'b1;
        end else begin
          state_s = WAIT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, capture registers, grant bookkeeping and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      prev_r        <= 4'b0000;
      pending_r     <= 4'b0000;
      sel_r         <= 2'd0;
      last_r        <= 2'd3;
      cnt_r         <= 16'd0;
      play_start_r  <= 1'b0;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      prev_r    <= bus.req_in;
      pending_r <= pending_s;
      if ((state_r == IDLE) && (state_s == START)) begin
        sel_r  <= win_s;
        last_r <= win_s;
      end
      if (state_r == WAIT) begin
        cnt_r <= cnt_r + 16'd1;
      end else begin
        cnt_r <= 16'd0;
      end
      play_start_r  <= (state_s == START);
      busy_r        <= (state_s != IDLE);
      timeout_err_r <= timeout_s;
    end
  end

  assign bus.play_start  = play_start_r;
  assign bus.play_sel    = sel_r;
  assign bus.busy        = busy_r;
  assign bus.pending     = pending_r;
  assign bus.timeout_err = timeout_err_r;

endmodule

// File: tb/tb_key_play_arbiter.sv
// Directed bench for key_play_arbiter: a cycle table for single/simultaneous presses,
// then hand-written sequences for fairness, held levels, timeout and mid-play reset.
module tb_key_play_arbiter;

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic       start;
    logic [1:0] sel;
    logic       busy;
    logic [3:0] pend;
    logic       terr;
  } vec_t;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;
  vec_t vecs [25];

  key_play_arbiter_if bus ();

  key_play_arbiter #(.TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic r, input logic [3:0] q, input logic d, input logic s,
                              input logic [1:0] sl, input logic b, input logic [3:0] p,
                              input logic t);
    vec_t v;
    v = '{r, q, d, s, sl, b, p, t};
    return v;
  endfunction

  function automatic logic [15:0] outs();
    return 16'({bus.play_start, bus.play_sel, bus.busy, bus.pending, bus.timeout_err});
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.req_in    = 4'b0000;
    bus.play_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Wait for the next grant, check its channel, then complete it with play_done.
  task automatic serve(input logic [1:0] exp_sel);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (bus.play_start) found = 1'b1;
    end
    check("serve_start", 16'(found), 16'd1);
    check("serve_sel", 16'(bus.play_sel), 16'(exp_sel));
    tick();
    bus.play_done = 1'b1;
    tick();
    bus.play_done = 1'b0;
    check("serve_idle", 16'(bus.busy), 16'd0);
  endtask

  // Go from idle to the first WAIT cycle of a grant to channel 0.
  task automatic enter_wait();
    bus.req_in = 4'b0001;
    tick();
    bus.req_in = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    logic found;
    int   n;
    int   starts;
    n_pass  = 0;
    n_total = 0;

    // single press; play_done in the 6th cycle after play_start -> 7 busy cycles
    vecs[0]  = mk(1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0001, 1'b0);
    vecs[1]  = mk(1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b0);
    vecs[2]  = mk(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0);
    vecs[3]  = mk(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0);
    vecs[4]  = mk(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0);
    vecs[5]  = mk(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0);
    vecs[6]  = mk(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0);
    vecs[7]  = mk(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0);
    vecs[8]  = mk(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);
    vecs[9]  = mk(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);
    // reset, then 1111 high at release: grants 0,1,2,3; play_done in START/IDLE ignored
    vecs[10] = mk(1'b1, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);
    vecs[11] = mk(1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, 4'b1111, 1'b0);
    vecs[12] = mk(1'b0, 4'b1111, 1'b0, 1'b1, 2'd0, 1'b1, 4'b1111, 1'b0);
    vecs[13] = mk(1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b1, 4'b1110, 1'b0);
    vecs[14] = mk(1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1110, 1'b0);
    vecs[15] = mk(1'b0, 4'b1111, 1'b0, 1'b1, 2'd1, 1'b1, 4'b1110, 1'b0);
    vecs[16] = mk(1'b0, 4'b1111, 1'b1, 1'b0, 2'd1, 1'b1, 4'b1100, 1'b0);
    vecs[17] = mk(1'b0, 4'b1111, 1'b1, 1'b0, 2'd1, 1'b0, 4'b1100, 1'b0);
    vecs[18] = mk(1'b0, 4'b1111, 1'b0, 1'b1, 2'd2, 1'b1, 4'b1100, 1'b0);
    vecs[19] = mk(1'b0, 4'b1111, 1'b0, 1'b0, 2'd2, 1'b1, 4'b1000, 1'b0);
    vecs[20] = mk(1'b0, 4'b1111, 1'b1, 1'b0, 2'd2, 1'b0, 4'b1000, 1'b0);
    vecs[21] = mk(1'b0, 4'b1111, 1'b0, 1'b1, 2'd3, 1'b1, 4'b1000, 1'b0);
    vecs[22] = mk(1'b0, 4'b1111, 1'b0, 1'b0, 2'd3, 1'b1, 4'b0000, 1'b0);
    vecs[23] = mk(1'b0, 4'b1111, 1'b1, 1'b0, 2'd3, 1'b0, 4'b0000, 1'b0);
    vecs[24] = mk(1'b0, 4'b1111, 1'b1, 1'b0, 2'd3, 1'b0, 4'b0000, 1'b0);

    reset         = 1'b1;
    bus.req_in    = 4'b0000;
    bus.play_done = 1'b0;
    tick();
    tick();
    check("reset_state", outs(), 16'd0);
    reset = 1'b0;

    for (int i = 0; i < 25; i++) begin
      reset         = vecs[i].rst;
      bus.req_in    = vecs[i].req;
      bus.play_done = vecs[i].done;
      tick();
      check($sformatf("vec%0d", i), outs(),
            16'({vecs[i].start, vecs[i].sel, vecs[i].busy, vecs[i].pend, vecs[i].terr}));
    end

    // fairness: grant 2, then 1011 pressed during its playback -> 3, 0, 1
    do_reset();
    bus.req_in = 4'b0100;
    tick();
    bus.req_in = 4'b0000;
    tick();
    check("rr_first_sel", 16'(bus.play_sel), 16'd2);
    bus.req_in = 4'b1011;
    tick();
    check("rr_pending", 16'(bus.pending), 16'b1011);
    bus.req_in    = 4'b0000;
    bus.play_done = 1'b1;
    tick();
    bus.play_done = 1'b0;
    serve(2'd3);
    serve(2'd0);
    serve(2'd1);
    check("rr_drained", 16'(bus.pending), 16'd0);

    // held level gives one grant; drop and re-raise gives a second
    do_reset();
    starts     = 0;
    bus.req_in = 4'b0010;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.play_start) starts++;
      bus.play_done = bus.busy & ~bus.play_start;
    end
    check("held_grants", 16'(starts), 16'd1);
    bus.req_in = 4'b0000;
    tick();
    bus.req_in = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.play_start) starts++;
      bus.play_done = bus.busy & ~bus.play_start;
    end
    bus.play_done = 1'b0;
    check("repress_grants", 16'(starts), 16'd2);

    // timeout: 8 cycles after entering WAIT, back in IDLE
    do_reset();
    enter_wait();
    found = 1'b0;
    n     = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      n++;
      if (bus.timeout_err) found = 1'b1;
    end
    check("timeout_seen", 16'(found), 16'd1);
    check("timeout_cycles", 16'(n), 16'd8);
    check("timeout_idle", 16'(bus.busy), 16'd0);
    tick();
    check("timeout_pulse_end", 16'(bus.timeout_err), 16'd0);

    // play_done on the timeout cycle wins
    do_reset();
    enter_wait();
    repeat (7) tick();
    bus.play_done = 1'b1;
    tick();
    bus.play_done = 1'b0;
    check("done_beats_timeout", 16'({bus.timeout_err, bus.busy}), 16'd0);

    // reset while waiting with 0110 pending
    do_reset();
    enter_wait();
    bus.req_in = 4'b0110;
    tick();
    check("pre_reset_pending", 16'({bus.busy, bus.pending}), 16'b10110);
    reset      = 1'b1;
    bus.req_in = 4'b0000;
    #1;
    check("async_reset_outs", outs(), 16'd0);
    tick();
    reset  = 1'b0;
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.play_start || bus.busy) starts++;
    end
    check("no_start_after_reset", 16'(starts), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
